// File: rtl/snake_key_dir.sv
// -----------------------------------------------------------------------------
// snake_key_dir
//
// Input front end for the snake game. The four raw push keys are active-low
// and asynchronous to clk. Each key goes through a two-flop synchronizer and
// then a debouncer. Every accepted press (a 1 -> 0 transition of the debounced
// level) produces a one-cycle pulse.
//
// The press pulses act as direction requests. A request is held as "pending"
// and is committed to the heading only on the movement step tick. A request
// that matches the heading, or that would turn the snake 180 degrees back
// into itself, is discarded.
//
// Ports
//   clk         system clock
//   rst_n       synchronous reset, active-low
//   key0_right  raw key, active-low, asynchronous
//   key1_left   raw key, active-low, asynchronous
//   key2_down   raw key, active-low, asynchronous
//   key3_up     raw key, active-low, asynchronous
//   step_tick   one-cycle pulse from the movement timer (commit point)
//   dir_reset   one-cycle pulse on game restart; heading back to right
//   key_pulse   registered press pulses {up, down, left, right}
//   dir_out     committed heading: 00 right, 01 left, 10 down, 11 up
//   dir_change  one-cycle pulse whenever dir_out takes a new value
// -----------------------------------------------------------------------------
module snake_key_dir #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key0_right,
  input  logic       key1_left,
  input  logic       key2_down,
  input  logic       key3_up,
  input  logic       step_tick,
  input  logic       dir_reset,
  output logic [3:0] key_pulse,
  output logic [1:0] dir_out,
  output logic       dir_change
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Raw keys packed so that the bit index equals the direction code.
  logic [3:0] key_raw;
  assign key_raw = {key3_up, key2_down, key1_left, key0_right};

  // ---------------------------------------------------------------------------
  // Per-key synchronizer, debouncer and press-pulse generator
  // ---------------------------------------------------------------------------
  logic [3:0] pulse_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_key
      logic             sync1_reg;
      logic             sync2_reg;
      logic             stable_reg;
      logic             stable_prev_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync1_reg       <= 1'b1;
          sync2_reg       <= 1'b1;
          stable_reg      <= 1'b1;
          stable_prev_reg <= 1'b1;
          cnt_reg         <= '0;
          pulse_reg[gi]   <= 1'b0;
        end else begin
          sync1_reg       <= key_raw[gi];
          sync2_reg       <= sync1_reg;
          stable_prev_reg <= stable_reg;
          // Pulse one cycle after the debounced level falls.
          pulse_reg[gi]   <= stable_prev_reg & ~stable_reg;

          if (sync2_reg == stable_reg) begin
            // Any return to the accepted level restarts the hold count.
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            stable_reg <= sync2_reg;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end
    end
  endgenerate

  assign key_pulse = pulse_reg;

  // ---------------------------------------------------------------------------
  // Direction request validation and arbitration
  // ---------------------------------------------------------------------------
  logic [1:0] dir_reg;
  logic       dir_change_reg;
  logic       pending_valid_reg;
  logic [1:0] pending_dir_reg;

  // The reference heading for validation. On a commit cycle this is the
  // heading about to be committed, so a same-cycle request is checked
  // against where the snake will actually be going.
  logic [1:0] ref_dir;
  assign ref_dir = (step_tick && pending_valid_reg) ? pending_dir_reg : dir_reg;

  // A request is usable only when it is on the other axis from ref_dir.
  // Bit1 of the code selects the axis (0 horizontal, 1 vertical). Equal and
  // opposite directions share that bit, so one compare rejects both.
  logic [3:0] req_mask;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_req
      localparam logic [1:0] CODE = 2'(gi);
      assign req_mask[gi] = pulse_reg[gi] & (CODE[1] != ref_dir[1]);
    end
  endgenerate

  // Only requests that survived validation take part in arbitration, with
  // priority up > down > left > right. Because the direction code equals
  // the bit index, the highest set bit wins.
  logic       req_valid;
  logic [1:0] req_dir;

  always_comb begin
    req_valid = 1'b0;
    req_dir   = 2'b00;
    for (int c = 0; c < 4; c++) begin
      if (req_mask[c]) begin
        req_valid = 1'b1;
        req_dir   = 2'(c);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending request and committed heading
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dir_reg           <= 2'b00;
      dir_change_reg    <= 1'b0;
      pending_valid_reg <= 1'b0;
      pending_dir_reg   <= 2'b00;
    end else if (dir_reset) begin
      // A restart overrides any tick or request in the same cycle.
      dir_reg           <= 2'b00;
      dir_change_reg    <= 1'b0;
      pending_valid_reg <= 1'b0;
    end else begin
      dir_change_reg <= 1'b0;

      if (step_tick && pending_valid_reg) begin
        dir_reg           <= pending_dir_reg;
        dir_change_reg    <= 1'b1;
        pending_valid_reg <= 1'b0;
      end

      // This comes last so that a request in the same cycle as a commit
      // becomes the new pending request. It waits for the next tick.
      if (req_valid) begin
        pending_dir_reg   <= req_dir;
        pending_valid_reg <= 1'b1;
      end
    end
  end

  assign dir_out    = dir_reg;
  assign dir_change = dir_change_reg;

endmodule

// File: tb/tb_snake_key_dir.sv
// -----------------------------------------------------------------------------
// tb_snake_key_dir
//
// Testbench for snake_key_dir with DEBOUNCE_CYCLES = 8.
//
// The reference model keeps a per-edge history of the raw key levels and of
// the reset. A debounced level is accepted when the synchronized history
// shows eight consecutive edges that disagree with it, with no reset among
// them. The heading model follows the request and commit rules directly.
// key_pulse, dir_out and dir_change are compared on every cycle. Directed
// scenarios also check pulse timing and final headings against constants.
// -----------------------------------------------------------------------------
module tb_snake_key_dir;

  localparam int DEB  = 8;
  localparam int MAXC = 8192;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] kraw;
  logic       tick;
  logic       dr;
  logic [3:0] key_pulse;
  logic [1:0] dir_out;
  logic       dir_change;

  snake_key_dir #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key0_right (kraw[0]),
    .key1_left  (kraw[1]),
    .key2_down  (kraw[2]),
    .key3_up    (kraw[3]),
    .step_tick  (tick),
    .dir_reset  (dr),
    .key_pulse  (key_pulse),
    .dir_out    (dir_out),
    .dir_change (dir_change)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle time %0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic       raw_h [4][MAXC];
  logic       rst_h [MAXC];
  logic       fell_h[4][MAXC];
  logic [3:0] m_stable;
  logic [3:0] m_pulse;
  logic [1:0] m_dir;
  logic       m_pv;
  logic [1:0] m_pd;
  logic       m_chg;
  int         cyc = 0;

  // The level that the second synchronizer stage presents to edge k.
  function automatic logic s2_at(input int i, input int k);
    if (k < 2) return 1'b1;
    if (rst_h[k-1] || rst_h[k-2]) return 1'b1;
    return raw_h[i][k-2];
  endfunction

  task automatic model_edge(input int e);
    logic [3:0] pulse_new;
    logic [1:0] refd;
    int         pick;
    bit         ok;
    for (int i = 0; i < 4; i++) raw_h[i][e] = kraw[i];
    rst_h[e] = !rst_n;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) fell_h[i][e] = 1'b0;
      m_stable = 4'hF; m_pulse = 4'h0; m_dir = 2'd0; m_pv = 1'b0; m_pd = 2'd0; m_chg = 1'b0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      pulse_new[i] = (e >= 1) && fell_h[i][e-1];
      ok = 1;
      for (int j = 0; j < DEB; j++) begin
        if (e - j < 0) ok = 0;
        else if (rst_h[e-j] || s2_at(i, e - j) == m_stable[i]) ok = 0;
      end
      fell_h[i][e] = ok && m_stable[i];
      if (ok) m_stable[i] = ~m_stable[i];
    end
    // Heading rules. Requests come from the pulses visible before this edge.
    if (dr) begin
      m_dir = 2'd0; m_pv = 1'b0; m_chg = 1'b0;
    end else begin
      m_chg = 1'b0;
      refd  = (tick && m_pv) ? m_pd : m_dir;
      pick  = -1;
      // Codes 3..0 = up, down, left, right; codes >= 2 are vertical.
      for (int c = 3; c >= 0; c--)
        if (pick < 0 && m_pulse[c] && ((c >= 2) != (refd >= 2))) pick = c;
      if (tick && m_pv) begin
        m_dir = m_pd; m_chg = 1'b1; m_pv = 1'b0;
      end
      if (pick >= 0) begin
        m_pd = 2'(pick); m_pv = 1'b1;
      end
    end
    m_pulse = pulse_new;
  endtask

  // ---------------- cycle driver ----------------
  int obs_cnt [4];
  int obs_last[4];

  task automatic clr_obs();
    for (int i = 0; i < 4; i++) begin obs_cnt[i] = 0; obs_last[i] = -1; end
  endtask

  task automatic run(input int n);
    for (int r = 0; r < n; r++) begin
      if (cyc >= MAXC) begin
        $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC);
        n_bad++;
        $fatal(1, "cycle budget exceeded");
      end
      @(posedge clk);
      model_edge(cyc);
      @(negedge clk);
      chk("key_pulse", 32'(key_pulse), 32'(m_pulse));
      chk("dir_out", 32'(dir_out), 32'(m_dir));
      chk("dir_change", 32'(dir_change), 32'(m_chg));
      for (int i = 0; i < 4; i++)
        if (key_pulse[i]) begin obs_cnt[i]++; obs_last[i] = cyc; end
      cyc++;
    end
  endtask

  task automatic do_tick();
    tick = 1'b1; run(1); tick = 1'b0;
  endtask

  task automatic do_dr();
    dr = 1'b1; run(1); dr = 1'b0;
  endtask

  task automatic press(input int k);
    kraw[k] = 1'b0; run(14); kraw[k] = 1'b1; run(12);
  endtask

  int n0;
  int hold[4];

  initial begin
    rst_n = 1'b0; kraw = 4'hF; tick = 1'b0; dr = 1'b0;
    clr_obs();
    run(3);
    chk("rst_key_pulse", 32'(key_pulse), 32'h0);
    chk("rst_dir_out", 32'(dir_out), 32'h0);
    chk("rst_dir_change", 32'(dir_change), 32'h0);
    rst_n = 1'b1;
    run(5);

    // Clean press of down: one pulse, ten edges after the first low sample.
    clr_obs();
    kraw[2] = 1'b0; n0 = cyc; run(20);
    kraw[2] = 1'b1; run(14);
    chk("clean_cnt", 32'(obs_cnt[2]), 32'd1);
    chk("clean_lat", 32'(obs_last[2]), 32'(n0 + 10));
    chk("clean_other", 32'(obs_cnt[0] + obs_cnt[1] + obs_cnt[3]), 32'd0);
    do_tick();
    chk("clean_dir", 32'(dir_out), 32'd2);
    chk("clean_chg", 32'(dir_change), 32'd1);
    run(1);
    chk("clean_chg_end", 32'(dir_change), 32'd0);

    // Bounce on up; then a 3-cycle glitch on right.
    clr_obs();
    kraw[3] = 1'b0; run(5);
    kraw[3] = 1'b1; run(1);
    kraw[3] = 1'b0; n0 = cyc; run(15);
    kraw[3] = 1'b1; run(14);
    chk("bounce_cnt", 32'(obs_cnt[3]), 32'd1);
    chk("bounce_lat", 32'(obs_last[3]), 32'(n0 + 10));
    kraw[0] = 1'b0; run(3);
    kraw[0] = 1'b1; run(15);
    chk("glitch_cnt", 32'(obs_cnt[0]), 32'd0);

    // Reversal and same-heading requests are dropped.
    do_dr();
    press(1); do_tick(); run(1);
    chk("reverse_dir", 32'(dir_out), 32'd0);
    press(0); do_tick();
    chk("same_dir", 32'(dir_out), 32'd0);
    chk("same_chg", 32'(dir_change), 32'd0);

    // Overwrite: down then up before the tick, so up is committed.
    press(2); press(3); do_tick();
    chk("overwrite_dir", 32'(dir_out), 32'd3);

    // Simultaneous left and down while heading up: left becomes pending.
    kraw[1] = 1'b0; kraw[2] = 1'b0; run(14);
    kraw = 4'hF; run(12);
    do_tick();
    chk("prio_dir", 32'(dir_out), 32'd1);

    // Coincident tick: pending down, left pulse lands on the tick cycle.
    do_dr();
    press(2);
    kraw[1] = 1'b0; run(11);
    do_tick();
    chk("coinc_dir1", 32'(dir_out), 32'd2);
    chk("coinc_chg1", 32'(dir_change), 32'd1);
    kraw[1] = 1'b1; run(12);
    do_tick();
    chk("coinc_dir2", 32'(dir_out), 32'd1);
    chk("coinc_chg2", 32'(dir_change), 32'd1);

    // Restart with a pending request and a tick in the same cycle.
    press(3);
    dr = 1'b1; tick = 1'b1; run(1); dr = 1'b0; tick = 1'b0;
    chk("restart_dir", 32'(dir_out), 32'd0);
    chk("restart_chg", 32'(dir_change), 32'd0);

    // Key held through reset: one pulse ten edges after reset release.
    kraw[0] = 1'b0; rst_n = 1'b0; run(3);
    chk("rst2_pulse", 32'(key_pulse), 32'h0);
    chk("rst2_dir", 32'(dir_out), 32'h0);
    clr_obs();
    rst_n = 1'b1; n0 = cyc; run(16);
    chk("held_cnt", 32'(obs_cnt[0]), 32'd1);
    chk("held_lat", 32'(obs_last[0]), 32'(n0 + 10));
    kraw[0] = 1'b1; run(12);

    // Randomized traffic checked cycle-by-cycle against the model.
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int r = 0; r < 3000; r++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          kraw[i] = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
          hold[i] = $urandom_range(1, 20);
        end
        hold[i]--;
      end
      tick  = ($urandom_range(0, 15) == 0);
      dr    = ($urandom_range(0, 199) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      run(1);
    end
    rst_n = 1'b1; tick = 1'b0; dr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
